// File: rtl/dma_mem_burst_bus.sv
// ---------------------------------------------------------------------------
// dma_mem_burst_bus
//   One DMA master and one on-chip word memory, joined by internal AXI-style
//   burst channels (AR/R for reads, AW/W/B for writes).
//   A page-fault request fetches a burst from memory and streams each beat
//   out on rd_data*. A write-back request writes a burst whose data is the
//   beat address itself. The read and write engines run independently.
//
// Ports
//   cpu_clk, cpu_rst               clock, synchronous active-high reset
//   dma_page_fault_happen/addr/    read request level, start word address,
//     burst_len                    beats minus 1
//   dma_page_fault_done            read burst complete (held until happen=0)
//   dma_write_back_happen/addr/    write request level, start word address,
//     burst_len                    beats minus 1
//   dma_write_back_done            write burst complete (held until happen=0)
//   rd_data_valid/rd_data/         one delivered read beat, its data and
//     rd_data_addr                 its word address
// ---------------------------------------------------------------------------
module dma_mem_burst_bus #(
    parameter int ADDR_WIDTH          = 32,
    parameter int READ_CHANNEL_WIDTH  = 32,
    parameter int READ_BURST_LEN      = 8,
    parameter int WRITE_CHANNEL_WIDTH = 32,
    parameter int WRITE_BURST_LEN     = 8,
    parameter int MEM_ADDR_WIDTH      = 6
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rst,
    input  logic                          dma_page_fault_happen,
    output logic                          dma_page_fault_done,
    input  logic [ADDR_WIDTH-1:0]         dma_page_fault_addr,
    input  logic [READ_BURST_LEN-1:0]     dma_page_fault_burst_len,
    input  logic                          dma_write_back_happen,
    output logic                          dma_write_back_done,
    input  logic [ADDR_WIDTH-1:0]         dma_write_back_addr,
    input  logic [WRITE_BURST_LEN-1:0]    dma_write_back_burst_len,
    output logic                          rd_data_valid,
    output logic [READ_CHANNEL_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0]         rd_data_addr
);

    localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]      ADDR_ONE = 1;
    localparam logic [READ_BURST_LEN-1:0]  RLEN_ONE = 1;
    localparam logic [WRITE_BURST_LEN-1:0] WLEN_ONE = 1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_DONE = 2'd3
    } rstate_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        W_RESP = 3'd3,
        W_DONE = 3'd4
    } wstate_t;

    // internal channels
    logic                           arvalid, arready;
    logic [ADDR_WIDTH-1:0]          araddr;
    logic [READ_BURST_LEN-1:0]      arlen;
    logic                           rvalid, rready, rlast;
    logic [READ_CHANNEL_WIDTH-1:0]  rdata;

    logic                           awvalid, awready;
    logic [ADDR_WIDTH-1:0]          awaddr;
    logic                           wvalid, wready, wlast;
    logic [WRITE_CHANNEL_WIDTH-1:0] wdata;
    logic                           bvalid, bready;

    logic [READ_CHANNEL_WIDTH-1:0]  mem [MEM_DEPTH];

    // =====================================================================
    // Master: read engine
    // =====================================================================
    rstate_t                   r_state, r_next;
    logic [ADDR_WIDTH-1:0]     r_req_addr;
    logic [READ_BURST_LEN-1:0] r_req_len;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state    <= R_IDLE;
            r_req_addr <= '0;
            r_req_len  <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && dma_page_fault_happen) begin
                r_req_addr <= dma_page_fault_addr;
                r_req_len  <= dma_page_fault_burst_len;
            end
        end
    end

    always_comb begin
        r_next              = r_state;
        arvalid             = 1'b0;
        rready              = 1'b0;
        dma_page_fault_done = 1'b0;
        case (r_state)
            R_IDLE: if (dma_page_fault_happen) r_next = R_ADDR;
            R_ADDR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) r_next = R_DONE;
            end
            R_DONE: begin
                dma_page_fault_done = 1'b1;
                if (!dma_page_fault_happen) r_next = R_IDLE;
            end
        endcase
    end

    assign araddr = r_req_addr;
    assign arlen  = r_req_len;

    // =====================================================================
    // Master: write engine. Keeps its own beat address; the write data is
    // the beat address itself.
    // =====================================================================
    wstate_t                    w_state, w_next;
    logic [ADDR_WIDTH-1:0]      m_waddr;
    logic [WRITE_BURST_LEN-1:0] m_wcnt;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            w_state <= W_IDLE;
            m_waddr <= '0;
            m_wcnt  <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && dma_write_back_happen) begin
                m_waddr <= dma_write_back_addr;
                m_wcnt  <= dma_write_back_burst_len;
            end else if (wvalid && wready) begin
                m_waddr <= m_waddr + ADDR_ONE;
                m_wcnt  <= m_wcnt - WLEN_ONE;
            end
        end
    end

    always_comb begin
        w_next              = w_state;
        awvalid             = 1'b0;
        wvalid              = 1'b0;
        bready              = 1'b0;
        dma_write_back_done = 1'b0;
        case (w_state)
            W_IDLE: if (dma_write_back_happen) w_next = W_ADDR;
            W_ADDR: begin
                awvalid = 1'b1;
                if (awready) w_next = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                if (wready && wlast) w_next = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_next = W_DONE;
            end
            W_DONE: begin
                dma_write_back_done = 1'b1;
                if (!dma_write_back_happen) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign awaddr = m_waddr;
    assign wdata  = WRITE_CHANNEL_WIDTH'(m_waddr);
    assign wlast  = (m_wcnt == '0);

    // =====================================================================
    // Slave: read side. The read port is synchronous, so the word for the
    // next beat is fetched on the edge that consumes the current one; this
    // keeps the R stream free of bubbles.
    // =====================================================================
    logic [ADDR_WIDTH-1:0]     s_raddr, s_raddr_nxt;
    logic [READ_BURST_LEN-1:0] s_rcnt;

    assign arready     = !rvalid;
    assign rlast       = (s_rcnt == '0);
    assign s_raddr_nxt = s_raddr + ADDR_ONE;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rvalid  <= 1'b0;
            s_raddr <= '0;
            s_rcnt  <= '0;
            rdata   <= '0;
        end else if (arvalid && arready) begin
            rvalid  <= 1'b1;
            s_raddr <= araddr;
            s_rcnt  <= arlen;
            rdata   <= mem[araddr[MEM_ADDR_WIDTH-1:0]];
        end else if (rvalid && rready) begin
            if (rlast) begin
                rvalid <= 1'b0;
            end else begin
                s_raddr <= s_raddr_nxt;
                s_rcnt  <= s_rcnt - RLEN_ONE;
                rdata   <= mem[s_raddr_nxt[MEM_ADDR_WIDTH-1:0]];
            end
        end
    end

    // =====================================================================
    // Slave: write side. B follows in the cycle after wlast.
    // =====================================================================
    logic                  s_wactive;
    logic [ADDR_WIDTH-1:0] s_waddr;

    assign awready = !s_wactive && !bvalid;
    assign wready  = s_wactive;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            s_wactive <= 1'b0;
            s_waddr   <= '0;
            bvalid    <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                s_wactive <= 1'b1;
                s_waddr   <= awaddr;
            end else if (wvalid && wready) begin
                s_waddr <= s_waddr + ADDR_ONE;
                if (wlast) begin
                    s_wactive <= 1'b0;
                    bvalid    <= 1'b1;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
        end
    end

    // Single write port; a same-edge read of the same word sees the old value.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (wvalid && wready) begin
            mem[s_waddr[MEM_ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    // =====================================================================
    // Read beat output
    // =====================================================================
    assign rd_data_valid = rvalid && rready;
    assign rd_data       = rd_data_valid ? rdata   : '0;
    assign rd_data_addr  = rd_data_valid ? s_raddr : '0;

endmodule

// File: tb/tb_dma_mem_burst_bus.sv
module tb_dma_mem_burst_bus;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        pf_happen, pf_done;
    logic [31:0] pf_addr;
    logic [7:0]  pf_len;
    logic        wb_happen, wb_done;
    logic [31:0] wb_addr;
    logic [7:0]  wb_len;
    logic        rd_valid;
    logic [31:0] rd_data, rd_addr;

    int n_assert = 0;
    int n_fail   = 0;

    // reference memory: 64 words, index = address mod 64
    logic [31:0] mem_m [64];

    dma_mem_burst_bus dut (
        .cpu_clk                 (cpu_clk),
        .cpu_rst                 (cpu_rst),
        .dma_page_fault_happen   (pf_happen),
        .dma_page_fault_done     (pf_done),
        .dma_page_fault_addr     (pf_addr),
        .dma_page_fault_burst_len(pf_len),
        .dma_write_back_happen   (wb_happen),
        .dma_write_back_done     (wb_done),
        .dma_write_back_addr     (wb_addr),
        .dma_write_back_burst_len(wb_len),
        .rd_data_valid           (rd_valid),
        .rd_data                 (rd_data),
        .rd_data_addr            (rd_addr)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
    endtask

    // Called at a falling edge with the read engine idle. Checks exact
    // per-cycle timing: beat k visible at the (k+2)th falling edge,
    // done at the (len+3)th, held for 'hold' extra cycles.
    task automatic do_read(input logic [31:0] a, input logic [7:0] l, input int hold);
        logic [31:0] ba;
        pf_happen = 1'b1; pf_addr = a; pf_len = l;
        @(negedge cpu_clk);
        chk("rd_first_idle", 32'(rd_valid), 32'd0);
        pf_addr = $urandom; pf_len = 8'($urandom);   // must not disturb burst
        for (int k = 0; k <= int'(l); k++) begin
            @(negedge cpu_clk);
            ba = a + 32'(k);
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_addr",  rd_addr, ba);
            chk("rd_data",  rd_data, mem_m[ba[5:0]]);
            chk("rd_done_early", 32'(pf_done), 32'd0);
        end
        @(negedge cpu_clk);
        chk("rd_valid_end", 32'(rd_valid), 32'd0);
        chk("rd_done", 32'(pf_done), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge cpu_clk);
            chk("rd_done_hold", 32'(pf_done), 32'd1);
        end
        pf_happen = 1'b0;
        @(negedge cpu_clk);
        chk("rd_done_clr", 32'(pf_done), 32'd0);
    endtask

    // Write: done visible at the (len+4)th falling edge; model updated after.
    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input int hold);
        logic [31:0] ba;
        wb_happen = 1'b1; wb_addr = a; wb_len = l;
        for (int i = 1; i <= int'(l) + 3; i++) begin
            @(negedge cpu_clk);
            if (i == 1) begin
                wb_addr = $urandom; wb_len = 8'($urandom);
            end
            chk("wr_done_early", 32'(wb_done), 32'd0);
        end
        @(negedge cpu_clk);
        chk("wr_done", 32'(wb_done), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge cpu_clk);
            chk("wr_done_hold", 32'(wb_done), 32'd1);
        end
        wb_happen = 1'b0;
        @(negedge cpu_clk);
        chk("wr_done_clr", 32'(wb_done), 32'd0);
        for (int k = 0; k <= int'(l); k++) begin
            ba = a + 32'(k);
            mem_m[ba[5:0]] = ba;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [7:0]  rl;
        cpu_rst = 1'b1;
        pf_happen = 1'b1; pf_addr = 32'd4; pf_len = 8'd3;   // ignored in reset
        wb_happen = 1'b1; wb_addr = 32'd4; wb_len = 8'd3;
        clear_model();
        repeat (3) @(negedge cpu_clk);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  rd_data, 32'd0);
        chk("rst_rd_addr",  rd_addr, 32'd0);
        chk("rst_pf_done",  32'(pf_done), 32'd0);
        chk("rst_wb_done",  32'(wb_done), 32'd0);
        pf_happen = 1'b0; wb_happen = 1'b0;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        chk("idle_rd_valid", 32'(rd_valid), 32'd0);

        // 1: 20-beat write, done held then released
        do_write(32'd8, 8'd19, 2);
        // 2: short read of written data
        do_read(32'd15, 8'd2, 1);
        // 3: 16 beats, then a single beat
        do_read(32'd8, 8'd15, 0);
        do_read(32'd8, 8'd0, 0);
        // 4: concurrent write and read on disjoint words
        fork
            do_write(32'd2, 8'd9, 3);
            do_read(32'd25, 8'd19, 0);
        join
        do_read(32'd0, 8'd15, 0);
        // 5: memory index wrap
        do_read(32'd62, 8'd3, 0);
        // address-width wrap on both engines
        do_write(32'hFFFF_FFFE, 8'd4, 0);
        do_read(32'hFFFF_FFFD, 8'd5, 0);

        // 6: reset in the middle of a 20-beat read
        pf_happen = 1'b1; pf_addr = 32'd8; pf_len = 8'd19;
        repeat (5) @(negedge cpu_clk);
        chk("mid_rd_valid", 32'(rd_valid), 32'd1);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        chk("rst_mid_valid", 32'(rd_valid), 32'd0);
        chk("rst_mid_done",  32'(pf_done), 32'd0);
        chk("rst_mid_data",  rd_data, 32'd0);
        @(negedge cpu_clk);
        chk("rst_mid_valid2", 32'(rd_valid), 32'd0);
        pf_happen = 1'b0;
        cpu_rst = 1'b0;
        clear_model();
        @(negedge cpu_clk);
        do_read(32'd0, 8'd63, 0);          // whole memory cleared
        do_write(32'd60, 8'd7, 1);
        do_read(32'd58, 8'd11, 0);

        // randomized sequential operations
        for (int it = 0; it < 14; it++) begin
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            rl = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 0) do_write(ra, rl, int'($urandom_range(0, 2)));
            else                           do_read(ra, rl, int'($urandom_range(0, 2)));
        end
        // maximum length bursts (256 beats)
        do_write(32'($urandom), 8'd255, 0);
        do_read(32'($urandom), 8'd255, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
